// File: rtl/debounce_ctrl_if.sv
// Signal bundle between a noisy-input source and the debouncer, plus the
// debounced drive toward a downstream register.
//   raw_in      : asynchronous noisy level from a switch or pin
//   clr_req     : synchronous request to force the accepted level to 0
//   dflop_in    : accepted (debounced) level, data input of downstream register
//   dflop_en    : one-cycle load strobe for the downstream register
//   dflop_clr_n : active-low clear strobe for the downstream register
//   edge_rise   : one-cycle pulse on an accepted 0->1 change
//   edge_fall   : one-cycle pulse on an accepted 1->0 change
// modport slave  : the debouncer side
// modport master : the side that drives raw_in/clr_req and consumes the outputs
interface debounce_ctrl_if;
  logic raw_in;
  logic clr_req;
  logic dflop_in;
  logic dflop_en;
  logic dflop_clr_n;
  logic edge_rise;
  logic edge_fall;

  modport slave (
    input  raw_in,
    input  clr_req,
    output dflop_in,
    output dflop_en,
    output dflop_clr_n,
    output edge_rise,
    output edge_fall
  );

  modport master (
    output raw_in,
    output clr_req,
    input  dflop_in,
    input  dflop_en,
    input  dflop_clr_n,
    input  edge_rise,
    input  edge_fall
  );
endinterface

// File: rtl/debounce_ctrl.sv
// Debouncer for an asynchronous level input. raw_in is brought into the clk
// domain through a two-flop synchronizer; a four-state FSM accepts a new
// level only after DEBOUNCE_CYCLES consecutive synchronized samples of it.
// All outputs are registered.
//   clk   : single clock, rising edge
//   reset : synchronous, active-low
//   bus   : debounce_ctrl_if.slave (raw_in, clr_req in; dflop_in, dflop_en,
//           dflop_clr_n, edge_rise, edge_fall out)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive samples needed to accept a level (2..2^CNT_W-1)
//   CNT_W           : width of the qualification counter
module debounce_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic              clk,
  input  logic              reset,
  debounce_ctrl_if.slave    bus
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_param
    $error("debounce_ctrl: DEBOUNCE_CYCLES=%0d out of range 2..%0d for CNT_W=%0d",
           DEBOUNCE_CYCLES, (2**CNT_W) - 1, CNT_W);
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1           <= 1'b0;
      sync2           <= 1'b0;
      state           <= STABLE_LO;
      cnt             <= '0;
      bus.dflop_in    <= 1'b0;
      bus.dflop_en    <= 1'b0;
      bus.edge_rise   <= 1'b0;
      bus.edge_fall   <= 1'b0;
      bus.dflop_clr_n <= 1'b0;
    end else begin
      sync1 <= bus.raw_in;
      sync2 <= sync1;

      // Strobes default low; only an accepted transition raises them.
      bus.dflop_en    <= 1'b0;
      bus.edge_rise   <= 1'b0;
      bus.edge_fall   <= 1'b0;
      bus.dflop_clr_n <= 1'b1;

      if (bus.clr_req) begin
        // Clear overrides any transition qualifying on this same edge.
        state           <= STABLE_LO;
        cnt             <= '0;
        bus.dflop_in    <= 1'b0;
        bus.dflop_clr_n <= 1'b0;
      end else begin
        unique case (state)
          STABLE_LO: begin
            if (sync2) begin
              state <= PEND_HI;
              cnt   <= CNT_ONE;
            end else begin
              cnt   <= '0;
            end
          end
          PEND_HI: begin
            if (!sync2) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state         <= STABLE_HI;
              cnt           <= '0;
              bus.dflop_in  <= 1'b1;
              bus.edge_rise <= 1'b1;
              bus.dflop_en  <= 1'b1;
            end else begin
              cnt   <= cnt + CNT_ONE;
            end
          end
          STABLE_HI: begin
            if (!sync2) begin
              state <= PEND_LO;
              cnt   <= CNT_ONE;
            end else begin
              cnt   <= '0;
            end
          end
          PEND_LO: begin
            if (sync2) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state         <= STABLE_LO;
              cnt           <= '0;
              bus.dflop_in  <= 1'b0;
              bus.edge_fall <= 1'b1;
              bus.dflop_en  <= 1'b1;
            end else begin
              cnt   <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= STABLE_LO;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Directed bench for debounce_ctrl with DEBOUNCE_CYCLES=4. Inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_debounce_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   n_rise;
  int   n_fall;
  int   n_en;

  debounce_ctrl_if bus ();

  debounce_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, tallying the strobes seen after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_rise += int'(bus.edge_rise);
      n_fall += int'(bus.edge_fall);
      n_en   += int'(bus.dflop_en);
    end
  endtask

  task automatic clear_tally();
    n_rise = 0;
    n_fall = 0;
    n_en   = 0;
  endtask

  initial begin
    int prev_lvl;
    int tgt;
    int runs;
    int len;
    int exp_rise;
    int exp_fall;
    logic lvl;

    checks   = 0;
    failures = 0;
    clear_tally();
    reset       = 1'b0;
    bus.raw_in  = 1'b0;
    bus.clr_req = 1'b0;

    // Reset state
    run(3);
    check("rst_dflop_in",   32'(bus.dflop_in),   32'd0);
    check("rst_dflop_en",   32'(bus.dflop_en),   32'd0);
    check("rst_edge_rise",  32'(bus.edge_rise),  32'd0);
    check("rst_edge_fall",  32'(bus.edge_fall),  32'd0);
    check("rst_dflop_clr_n",32'(bus.dflop_clr_n),32'd0);

    reset = 1'b1;
    run(1);
    check("post_rst_clr_n", 32'(bus.dflop_clr_n), 32'd1);
    run(3);
    check("idle_lo", 32'(bus.dflop_in), 32'd0);

    // Held rise: accepted at edge 6, strobes for that cycle only
    bus.raw_in = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      run(1);
      check("rise_wait_in", 32'(bus.dflop_in), 32'd0);
      check("rise_wait_en", 32'(bus.dflop_en), 32'd0);
    end
    run(1);
    check("rise_e6_in",   32'(bus.dflop_in),  32'd1);
    check("rise_e6_rise", 32'(bus.edge_rise), 32'd1);
    check("rise_e6_en",   32'(bus.dflop_en),  32'd1);
    check("rise_e6_fall", 32'(bus.edge_fall), 32'd0);
    run(1);
    check("rise_e7_in",   32'(bus.dflop_in),  32'd1);
    check("rise_e7_rise", 32'(bus.edge_rise), 32'd0);
    check("rise_e7_en",   32'(bus.dflop_en),  32'd0);
    run(3);

    // Clear while stable high, raw still high -> re-qualify from PEND_HI
    bus.clr_req = 1'b1;
    run(1);
    check("clr_clr_n", 32'(bus.dflop_clr_n), 32'd0);
    check("clr_in",    32'(bus.dflop_in),    32'd0);
    check("clr_rise",  32'(bus.edge_rise),   32'd0);
    check("clr_fall",  32'(bus.edge_fall),   32'd0);
    check("clr_en",    32'(bus.dflop_en),    32'd0);
    bus.clr_req = 1'b0;
    run(1);
    check("clr_rel_clr_n", 32'(bus.dflop_clr_n), 32'd1);
    check("clr_rel_in",    32'(bus.dflop_in),    32'd0);
    run(2);
    check("clr_req3_in",   32'(bus.dflop_in),    32'd0);
    run(1);
    check("clr_req4_in",   32'(bus.dflop_in),    32'd1);
    check("clr_req4_rise", 32'(bus.edge_rise),   32'd1);
    run(3);

    // Low glitch of 3 samples while high: no change, no strobes
    clear_tally();
    bus.raw_in = 1'b0;
    run(3);
    bus.raw_in = 1'b1;
    run(10);
    check("glitch_lo_in",   32'(bus.dflop_in), 32'd1);
    check("glitch_lo_rise", 32'(n_rise),       32'd0);
    check("glitch_lo_fall", 32'(n_fall),       32'd0);
    check("glitch_lo_en",   32'(n_en),         32'd0);

    // Held fall
    bus.raw_in = 1'b0;
    run(5);
    check("fall_wait_in", 32'(bus.dflop_in), 32'd1);
    run(1);
    check("fall_e6_in",   32'(bus.dflop_in),  32'd0);
    check("fall_e6_fall", 32'(bus.edge_fall), 32'd1);
    check("fall_e6_en",   32'(bus.dflop_en),  32'd1);
    check("fall_e6_rise", 32'(bus.edge_rise), 32'd0);
    run(1);
    check("fall_e7_fall", 32'(bus.edge_fall), 32'd0);

    // Back high, then reset while in PEND_LO with cnt=2
    bus.raw_in = 1'b1;
    run(8);
    check("rehigh_in", 32'(bus.dflop_in), 32'd1);
    bus.raw_in = 1'b0;
    run(4);
    check("pend_lo_in", 32'(bus.dflop_in), 32'd1);
    reset = 1'b0;
    run(1);
    check("midrst_in",    32'(bus.dflop_in),   32'd0);
    check("midrst_en",    32'(bus.dflop_en),   32'd0);
    check("midrst_rise",  32'(bus.edge_rise),  32'd0);
    check("midrst_fall",  32'(bus.edge_fall),  32'd0);
    check("midrst_clr_n", 32'(bus.dflop_clr_n),32'd0);
    reset = 1'b1;
    clear_tally();
    run(1);
    check("midrst_rel_clr_n", 32'(bus.dflop_clr_n), 32'd1);
    run(8);
    check("midrst_after_in",  32'(bus.dflop_in), 32'd0);
    check("midrst_after_fall",32'(n_fall),       32'd0);

    // High for 3 cycles then low: never accepted
    clear_tally();
    bus.raw_in = 1'b1;
    run(3);
    bus.raw_in = 1'b0;
    run(12);
    check("short_hi_in",   32'(bus.dflop_in), 32'd0);
    check("short_hi_rise", 32'(n_rise),       32'd0);
    check("short_hi_en",   32'(n_en),         32'd0);

    // Clear on the qualifying edge of a rise wins, then re-qualification
    bus.raw_in = 1'b1;
    run(5);
    bus.clr_req = 1'b1;
    run(1);
    check("clrq_rise",  32'(bus.edge_rise),   32'd0);
    check("clrq_en",    32'(bus.dflop_en),    32'd0);
    check("clrq_in",    32'(bus.dflop_in),    32'd0);
    check("clrq_clr_n", 32'(bus.dflop_clr_n), 32'd0);
    bus.clr_req = 1'b0;
    run(3);
    check("clrq_req3_in",  32'(bus.dflop_in),  32'd0);
    run(1);
    check("clrq_req4_in",  32'(bus.dflop_in),  32'd1);
    check("clrq_req4_rise",32'(bus.edge_rise), 32'd1);

    // Clear held three cycles
    bus.clr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run(1);
      check("clr_hold_clr_n", 32'(bus.dflop_clr_n), 32'd0);
      check("clr_hold_in",    32'(bus.dflop_in),    32'd0);
    end
    bus.clr_req = 1'b0;
    run(1);
    check("clr_hold_rel", 32'(bus.dflop_clr_n), 32'd1);
    run(10);
    check("clr_hold_reacq", 32'(bus.dflop_in), 32'd1);

    // Bounce of 1-3 cycle runs followed by a 20-cycle hold
    prev_lvl = 1;
    for (int seg = 0; seg < 8; seg++) begin
      tgt  = (seg % 2 == 0) ? 1 - prev_lvl : int'($urandom_range(0, 1));
      runs = int'($urandom_range(3, 6));
      lvl  = ~bus.raw_in;
      clear_tally();
      for (int r = 0; r < runs; r++) begin
        bus.raw_in = lvl;
        len = int'($urandom_range(1, 3));
        run(len);
        lvl = ~lvl;
      end
      bus.raw_in = tgt[0];
      run(20);
      exp_rise = (tgt == 1 && prev_lvl == 0) ? 1 : 0;
      exp_fall = (tgt == 0 && prev_lvl == 1) ? 1 : 0;
      check("bounce_level", 32'(bus.dflop_in), 32'(tgt));
      check("bounce_rise",  32'(n_rise),       32'(exp_rise));
      check("bounce_fall",  32'(n_fall),       32'(exp_fall));
      check("bounce_en",    32'(n_en),         32'(exp_rise + exp_fall));
      prev_lvl = tgt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
